mem_access_arbiter: RTL and testbench
=====================================

# mem_access_arbiter

Sequencer and arbiter for the single byte-addressable RAM port of the multicycle MIPS CPU. It shares the RAM between the instruction-fetch requester (PC/IR path) and the data requester (MAR/MDR path), and checks alignment and range. It drives the RAM enable, read/write and size lines and waits for the memory-operation-complete handshake. It also sign- or zero-extends loaded data. It sits between the control unit/datapath registers and the RAM module.

## Interface
- ADDR_W, 9, RAM byte-address width (512 bytes)
- TIMEOUT, 15, maximum cycles to wait for mem_moc before flagging an error
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  instruction fetch request (always a word read)
- if_addr  in  32  fetch byte address
- if_ack  out  1  one-cycle completion pulse for fetch
- if_err  out  1  valid with if_ack; fetch misaligned, out of range or timed out
- if_rdata  out  32  fetched word, valid with if_ack
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- d_sign  in  1  sign-extend byte/halfword loads
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-justified
- d_ack  out  1  one-cycle completion pulse for data
- d_err  out  1  valid with d_ack; misaligned, illegal size, out of range or timed out
- d_rdata  out  32  extended load data, valid with d_ack
- mem_en  out  1  RAM enable
- mem_rw  out  1  1 = write, 0 = read
- mem_size  out  2  access size to RAM, same encoding as d_size
- mem_addr  out  ADDR_W  RAM byte address
- mem_wdata  out  32  store data to RAM
- mem_rdata  in  32  RAM read data, right-justified
- mem_moc  in  1  RAM operation complete

## Operation
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE: sample requests.
  - Single requester: grant it.
  - Both requesting: grant the one not granted last. last_grant resets to fetch, so data wins the first tie.
  - The granted address, size, we and wdata are latched. The requester need not hold them afterwards.
- Checks in IDLE, using the latched values:
  - halfword needs addr[0]=0; word needs addr[1:0]=00.
  - d_size=11 is illegal.
  - Any nonzero addr bit at position ADDR_W or above is out of range.
  - A failed check goes to ERR with no RAM access.
  - A passing request goes to BUSY.
- BUSY:
  - mem_en=1; mem_rw, mem_size, mem_addr (latched addr[ADDR_W-1:0]) and mem_wdata are held stable.
  - mem_moc=1 sampled at an edge → capture mem_rdata, go to DONE.
  - A wait counter reaching TIMEOUT BUSY cycles without mem_moc → ERR.
- DONE: the granted requester's ack=1 for one cycle, rdata valid; next state IDLE.
- ERR: the granted requester's ack=1 and err=1 for one cycle; rdata=0; next state IDLE.
- Load extension:
  - byte: rdata[7:0], upper bits filled with rdata[7] if d_sign else 0.
  - halfword: rdata[15:0], extended from rdata[15] in the same way.
  - word: unchanged.
  - Stores return d_rdata=0.
- Only one transaction is ever in flight. A request arriving during BUSY/DONE/ERR waits, and is taken in IDLE if still asserted.

## Timing
- Reset (reset=0 at an edge), from any state including mid-transaction:
  - state=IDLE, last_grant=fetch, wait counter=0.
  - All outputs 0: mem_en, mem_rw, mem_size, mem_addr, mem_wdata, acks, errs, rdata.
  - An aborted transaction produces no ack.
- Latency:
  - Request sampled in IDLE at edge k; BUSY from cycle k+1.
  - mem_moc seen at edge k+1+n (n≥1 BUSY cycles); ack high in the following cycle.
  - Minimum: ack 2 cycles after the sampling edge.
  - Error path: ack+err exactly 1 cycle after the sampling edge.
- mem_en falls on the edge that enters DONE/ERR.
- Requester must deassert req by the edge that ends its ack cycle, or a new transaction starts from IDLE.
- Acks are registered outputs; if_ack and d_ack are never high together.
- Wait counter clears on entry to BUSY.

## Test plan
- Reset, then if_req with if_addr=0x4, RAM word 0x8C220008 at address 4, mem_moc 1 cycle after mem_en → mem_en high 1 cycle with mem_addr=4, mem_size=10; if_ack 2 cycles after request with if_rdata=0x8C220008 and if_err=0.
- d_req load byte, d_sign=1, mem_rdata=0x000000F0 → d_rdata=0xFFFFFFF0. Repeat with d_sign=0 → 0x000000F0. Halfword 0x8001 signed → 0xFFFF8001.
- d_req store word at d_addr=0x2A (misaligned) → no mem_en, d_ack+d_err one cycle after request. Store at 0x200 with ADDR_W=9 → same error.
- if_req and d_req held high together for three transactions → grant order data, fetch, data; acks never coincident.
- mem_moc held low → ERR after TIMEOUT=15 BUSY cycles, err asserted with ack. Separately, reset=0 during BUSY → next cycle all outputs 0, no ack, FSM IDLE.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Arbitrates the single byte-addressable RAM port between instruction fetch
//   and data access. It checks alignment, size and range, sequences the RAM
//   enable / mem_moc handshake with a timeout, and extends loaded data.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-low reset
//   if_req/if_addr             fetch request (always a word read)
//   if_ack/if_err/if_rdata     one-cycle fetch completion, error flag, word
//   d_req/d_we/d_size/d_sign   data request, store flag, size, sign-extend
//   d_addr/d_wdata             data byte address, right-justified store data
//   d_ack/d_err/d_rdata        one-cycle data completion, error flag, load data
//   mem_en/mem_rw/mem_size     RAM enable, write flag, access size
//   mem_addr/mem_wdata         RAM byte address, store data
//   mem_rdata/mem_moc          RAM read data, operation complete
module mem_access_arbiter #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_sign,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_moc
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  localparam int unsigned      CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]    WAIT_LAST = CW'(TIMEOUT - 1);

  state_t          state, state_n;
  logic            last_grant;   // 1 = data was granted last
  logic            owner;        // 1 = data owns the current transaction
  logic            owner_n;
  logic            we_q, sign_q;
  logic [1:0]      size_q;
  logic [CW-1:0]   wait_cnt;

  logic            take, take_d, bad;
  logic [31:0]     sel_addr, sel_wdata;
  logic [1:0]      sel_size;
  logic            sel_we, sel_sign;

  function automatic logic [31:0] load_ext(input logic [31:0] r,
                                           input logic [1:0]  sz,
                                           input logic        sg);
    case (sz)
      2'b00:   return {{24{sg & r[7]}}, r[7:0]};
      2'b01:   return {{16{sg & r[15]}}, r[15:0]};
      default: return r;
    endcase
  endfunction

  // The checks run on the same values that are latched at the sampling edge,
  // so the error decision is ready in time for ERR on that edge.
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    take      = 1'b0;
    take_d    = 1'b0;
    bad       = 1'b0;
    sel_addr  = if_addr;
    sel_size  = 2'b10;
    sel_we    = 1'b0;
    sel_sign  = 1'b0;
    sel_wdata = '0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          take    = 1'b1;
          take_d  = d_req && (!if_req || !last_grant);
          owner_n = take_d;
          if (take_d) begin
            sel_addr  = d_addr;
            sel_size  = d_size;
            sel_we    = d_we;
            sel_sign  = d_sign;
            sel_wdata = d_we ? d_wdata : '0;
          end
          bad = (sel_size == 2'b11)
             || (sel_size == 2'b01 && sel_addr[0])
             || (sel_size == 2'b10 && sel_addr[1:0] != 2'b00)
             || (|sel_addr[31:ADDR_W]);
          state_n = bad ? ERR : BUSY;
        end
      end
      BUSY: begin
        if (mem_moc)                    state_n = DONE;
        else if (wait_cnt == WAIT_LAST) state_n = ERR;
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      size_q     <= '0;
      wait_cnt   <= '0;
      mem_en     <= 1'b0;
      mem_rw     <= 1'b0;
      mem_size   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      if (take) begin
        last_grant <= take_d;
        we_q       <= sel_we;
        sign_q     <= sel_sign;
        size_q     <= sel_size;
      end
      wait_cnt <= (state == BUSY) ? wait_cnt + 1'b1 : '0;

      mem_en <= (state_n == BUSY);
      if (state == IDLE && state_n == BUSY) begin
        mem_rw    <= sel_we;
        mem_size  <= sel_size;
        mem_addr  <= sel_addr[ADDR_W-1:0];
        mem_wdata <= sel_wdata;
      end else if (state_n != BUSY) begin
        mem_rw    <= 1'b0;
        mem_size  <= '0;
        mem_addr  <= '0;
        mem_wdata <= '0;
      end

      if_ack   <= (state_n == DONE || state_n == ERR) && !owner_n;
      if_err   <= (state_n == ERR) && !owner_n;
      d_ack    <= (state_n == DONE || state_n == ERR) && owner_n;
      d_err    <= (state_n == ERR) && owner_n;
      if_rdata <= (state_n == DONE && !owner_n) ? mem_rdata : '0;
      d_rdata  <= (state_n == DONE && owner_n && !we_q)
                  ? load_ext(mem_rdata, size_q, sign_q) : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter
//   Directed bench for mem_access_arbiter. Stimulus pushes expected acks and
//   expected RAM accesses into queues; a RAM responder and an ack monitor pop
//   and compare them independently of the stimulus flow.
module tb_mem_access_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_ack, if_err;
  logic [31:0]   if_addr, if_rdata;
  logic          d_req, d_we, d_sign, d_ack, d_err;
  logic [1:0]    d_size;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic          mem_en, mem_rw, mem_moc;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  mem_access_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_sign(d_sign),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err),
    .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_moc(mem_moc)
  );

  always #5 clk = ~clk;

  typedef struct { bit d; bit err; logic [31:0] rdata; int lat; } exp_t;
  typedef struct { bit rw; logic [1:0] size; logic [AW-1:0] addr; logic [31:0] wdata; } mexp_t;

  exp_t        sb[$];
  mexp_t       mq[$];
  logic [31:0] tbl [int];

  int checks = 0, passed = 0;
  int cyc = 0, t0 = 0, acks = 0, en_cnt = 0, burst = 0;
  int resp_delay = 1;
  bit resp_on = 1'b1;
  logic en_d = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic exp_ack(input bit d, input bit err, input logic [31:0] rd, input int lat);
    exp_t e;
    e.d = d; e.err = err; e.rdata = rd; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic exp_mem(input bit rw, input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] wd);
    mexp_t m;
    m.rw = rw; m.size = sz; m.addr = a; m.wdata = wd;
    mq.push_back(m);
  endtask

  // Ack monitor
  always @(negedge clk) begin
    if (reset === 1'b1 && (if_ack || d_ack)) begin
      chk("ack_exclusive", {63'd0, if_ack & d_ack}, 64'd0);
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ack: got if_ack=%0b d_ack=%0b expected none", if_ack, d_ack);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_owner", {63'd0, d_ack}, {63'd0, e.d});
        chk("ack_err", {63'd0, d_ack ? d_err : if_err}, {63'd0, e.err});
        chk("ack_rdata", {32'd0, d_ack ? d_rdata : if_rdata}, {32'd0, e.rdata});
        if (e.lat >= 0) chk("ack_latency", 64'(cyc - t0 + 1), 64'(e.lat));
      end
      acks++;
    end
  end

  // RAM responder: checks each access on mem_en rise, answers after resp_delay
  always @(negedge clk) begin
    mem_moc = 1'b0;
    if (mem_en === 1'b1) begin
      if (!en_d) begin
        burst = 0;
        if (mq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_mem_access: got addr 0x%0h expected no access", mem_addr);
        end else begin
          mexp_t m;
          m = mq.pop_front();
          chk("mem_rw", {63'd0, mem_rw}, {63'd0, m.rw});
          chk("mem_size", {62'd0, mem_size}, {62'd0, m.size});
          chk("mem_addr", 64'(mem_addr), 64'(m.addr));
          chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, m.wdata});
        end
      end
      burst++;
      en_cnt++;
      if (resp_on && burst == resp_delay) begin
        mem_moc   = 1'b1;
        mem_rdata = tbl.exists(int'(mem_addr)) ? tbl[int'(mem_addr)] : 32'hBAD0BAD0;
      end
    end
    en_d = mem_en;
  end

  task automatic wait_acks(input int n);
    int target = acks + n;
    int i = 0;
    while (acks < target && i < 60) begin
      @(posedge clk);
      i++;
    end
    if (acks < target) begin
      checks++;
      $display("FAIL ack_wait_timeout: got %0d acks expected %0d", acks, target);
    end
  endtask

  task automatic issue_if(input logic [31:0] a);
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    @(posedge clk); #1;
    t0 = cyc;
    if_req = 1'b0; if_addr = 32'hFFFF_FFFF;
    wait_acks(1);
  endtask

  task automatic issue_d(input bit we, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_size = sz; d_sign = sg; d_addr = a; d_wdata = wd;
    @(posedge clk); #1;
    t0 = cyc;
    // Scramble the request fields: the DUT must have latched them.
    d_req = 1'b0; d_we = ~we; d_size = 2'b11; d_sign = ~sg;
    d_addr = 32'hFFFF_FFFF; d_wdata = 32'h1234_5678;
    wait_acks(1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctrl"}, {56'd0, if_ack, if_err, d_ack, d_err, mem_en, mem_rw, mem_size}, 64'd0);
    chk({nm, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({nm, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
    chk({nm, "_rdata"}, {if_rdata, d_rdata}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  int e0, a0;

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = '0; d_sign = 1'b0; d_addr = '0; d_wdata = '0;
    mem_moc = 1'b0; mem_rdata = '0;
    tbl[4]    = 32'h8C22_0008;
    tbl[9'h10] = 32'h0000_00F0;
    tbl[9'h12] = 32'h0000_8001;
    tbl[9'h20] = 32'h8000_0001;
    tbl[9'h40] = 32'h1122_3344;
    tbl[9'h44] = 32'h5566_7788;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    // Fetch word at 4, moc one cycle after mem_en
    e0 = en_cnt;
    exp_mem(1'b0, 2'b10, 9'h004, 32'h0);
    exp_ack(1'b0, 1'b0, 32'h8C22_0008, 2);
    issue_if(32'h4);
    chk("fetch_mem_en_cycles", 64'(en_cnt - e0), 64'd1);

    // Loads with extension
    exp_mem(1'b0, 2'b00, 9'h010, 32'h0);
    exp_ack(1'b1, 1'b0, 32'hFFFF_FFF0, 2);
    issue_d(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    exp_mem(1'b0, 2'b00, 9'h010, 32'h0);
    exp_ack(1'b1, 1'b0, 32'h0000_00F0, 2);
    issue_d(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    exp_mem(1'b0, 2'b01, 9'h012, 32'h0);
    exp_ack(1'b1, 1'b0, 32'hFFFF_8001, 2);
    issue_d(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    resp_delay = 3;
    exp_mem(1'b0, 2'b01, 9'h012, 32'h0);
    exp_ack(1'b1, 1'b0, 32'h0000_8001, 4);
    issue_d(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    resp_delay = 1;
    exp_mem(1'b0, 2'b10, 9'h020, 32'h0);
    exp_ack(1'b1, 1'b0, 32'h8000_0001, 2);
    issue_d(1'b0, 2'b10, 1'b1, 32'h20, 32'h0);

    // Stores return zero data
    exp_mem(1'b1, 2'b10, 9'h024, 32'hCAFE_F00D);
    exp_ack(1'b1, 1'b0, 32'h0, 2);
    issue_d(1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFE_F00D);
    exp_mem(1'b1, 2'b00, 9'h031, 32'h0000_00AB);
    exp_ack(1'b1, 1'b0, 32'h0, 2);
    issue_d(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_00AB);

    // Error paths: no RAM access, ack+err one cycle after sampling
    exp_ack(1'b1, 1'b1, 32'h0, 1);
    issue_d(1'b1, 2'b10, 1'b0, 32'h2A, 32'h5555_5555);
    exp_ack(1'b1, 1'b1, 32'h0, 1);
    issue_d(1'b1, 2'b10, 1'b0, 32'h200, 32'h5555_5555);
    exp_ack(1'b1, 1'b1, 32'h0, 1);
    issue_d(1'b0, 2'b01, 1'b1, 32'h13, 32'h0);
    exp_ack(1'b1, 1'b1, 32'h0, 1);
    issue_d(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    exp_ack(1'b0, 1'b1, 32'h0, 1);
    issue_if(32'h6);
    exp_ack(1'b0, 1'b1, 32'h0, 1);
    issue_if(32'h1000);

    // Timeout: 15 BUSY cycles without moc, ack+err in the 16th cycle
    resp_on = 1'b0;
    e0 = en_cnt;
    exp_mem(1'b0, 2'b10, 9'h008, 32'h0);
    exp_ack(1'b0, 1'b1, 32'h0, 16);
    issue_if(32'h8);
    chk("timeout_mem_en_cycles", 64'(en_cnt - e0), 64'(TO));

    // Reset during BUSY aborts with no ack
    exp_mem(1'b0, 2'b10, 9'h00C, 32'h0);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'hC;
    @(posedge clk); #1;
    if_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_reset", {63'd0, mem_en}, 64'd1);
    a0 = acks;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("reset_busy");
    @(negedge clk);
    reset = 1'b1;
    resp_on = 1'b1;
    repeat (4) @(posedge clk);
    chk("reset_busy_no_ack", 64'(acks - a0), 64'd0);

    // Both requesting after reset: data, fetch, data
    exp_mem(1'b0, 2'b10, 9'h040, 32'h0);
    exp_mem(1'b0, 2'b10, 9'h044, 32'h0);
    exp_mem(1'b0, 2'b10, 9'h040, 32'h0);
    exp_ack(1'b1, 1'b0, 32'h1122_3344, -1);
    exp_ack(1'b0, 1'b0, 32'h5566_7788, -1);
    exp_ack(1'b1, 1'b0, 32'h1122_3344, -1);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_sign = 1'b0; d_addr = 32'h40; d_wdata = '0;
    wait_acks(3);
    #1;
    if_req = 1'b0; d_req = 1'b0;
    repeat (6) @(posedge clk);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("mem_queue_drained", 64'(mq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
